// File: rtl/cache_wt_nway.sv
// cache_wt_nway: N-way set-associative write-through/no-write-allocate cache with IO window and flush.
// Define CACHE_WT_STATS_EN to add saturating stat_hits/stat_misses counters for cached reads.
module cache_wt_nway #(
  parameter int          WAYS       = 2,
  parameter int          SETS       = 64,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] IO_BASE    = 32'hF000_0000,
  parameter logic [31:0] IO_MASK    = 32'hF000_0000,
  parameter int          BURST_W    = 8
) (
  input  logic               clk,
  input  logic               rest,
  input  logic [31:0]        s0_address,
  input  logic [3:0]         s0_byteEnable,
  input  logic               s0_read,
  input  logic               s0_write,
  input  logic [31:0]        s0_writeData,
  output logic               s0_waitRequest,
  output logic [31:0]        s0_readData,
  output logic               s0_readDataValid,
  output logic [31:0]        m0_address,
  output logic [3:0]         m0_byteEnable,
  output logic               m0_read,
  output logic               m0_write,
  output logic [31:0]        m0_writeData,
  input  logic               m0_waitRequest,
  input  logic [31:0]        m0_readData,
  input  logic               m0_readDataValid,
  output logic               m0_beginBurstTransfer,
  output logic [BURST_W-1:0] m0_burstCount,
  input  logic               flush_req,
`ifdef CACHE_WT_STATS_EN
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
`endif
  output logic               flush_done
);
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TW  = 32 - OFF - IDX;
  localparam int WW  = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_DATA, WR_BUS, IO_REQ, IO_DATA, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] addr, wdata, rd_hit, merged;
  logic [3:0] be;
  logic wr, flush_pend, first, accept, io, hit, vic_inv, victim_valid, fill_beat, last_beat, unused_bits;
  logic [SETS-1:0] valid [WAYS];
  logic [WW-1:0] ptr [SETS];
  logic [TW-1:0] tag_mem [WAYS][SETS];
  logic [31:0] data_mem [WAYS][SETS*LINE_WORDS];
  logic [TW-1:0] rd_tag [WAYS];
  logic [31:0] rd_data [WAYS];
  logic [WW-1:0] hit_way, vic, victim;
  logic [OFF-3:0] beat, wo, a_wo;
  logic [IDX-1:0] fl_cnt, idx, a_idx;
  logic [TW-1:0] tag;
  assign idx = addr[OFF+IDX-1:OFF];
  assign wo = addr[OFF-1:2];
  assign tag = addr[31:OFF+IDX];
  assign a_idx = s0_address[OFF+IDX-1:OFF];
  assign a_wo = s0_address[OFF-1:2];
  assign unused_bits = ^addr[1:0];
  assign io = (s0_address & IO_MASK) == IO_BASE;
  assign s0_waitRequest = rest || state != IDLE || flush_pend;
  assign accept = !s0_waitRequest && (s0_read || s0_write);
  assign fill_beat = !rest && state == FILL_DATA && m0_readDataValid;
  assign last_beat = fill_beat && &beat;
  assign rd_hit = rd_data[hit_way];
  assign merged = {be[3] ? wdata[31:24] : rd_hit[31:24], be[2] ? wdata[23:16] : rd_hit[23:16],
                   be[1] ? wdata[15:8] : rd_hit[15:8], be[0] ? wdata[7:0] : rd_hit[7:0]};
  // Hit detection plus victim choice: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vic = ptr[idx];
    vic_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[i][idx] && rd_tag[i] == tag) begin
        hit = 1'b1;
        hit_way = WW'(i);
      end
      if (!valid[i][idx]) begin
        vic_inv = 1'b1;
        vic = WW'(i);
      end
    end
  end
  always_comb begin
    state_n = state;
    s0_readData = '0;
    s0_readDataValid = 1'b0;
    m0_address = '0;
    m0_byteEnable = '0;
    m0_read = 1'b0;
    m0_write = 1'b0;
    m0_writeData = '0;
    m0_beginBurstTransfer = 1'b0;
    m0_burstCount = '0;
    flush_done = 1'b0;
    if (!rest)
      case (state)
        IDLE: state_n = flush_pend ? FLUSH : !(s0_read || s0_write) ? IDLE : io ? IO_REQ : LOOKUP;
        LOOKUP: begin
          s0_readDataValid = !wr && hit;
          s0_readData = !wr && hit ? rd_hit : '0;
          state_n = wr ? WR_BUS : hit ? IDLE : FILL_REQ;
        end
        FILL_REQ: begin
          m0_read = 1'b1;
          m0_address = {addr[31:OFF], {OFF{1'b0}}};
          m0_byteEnable = 4'hF;
          m0_burstCount = BURST_W'(LINE_WORDS);
          m0_beginBurstTransfer = first;
          state_n = m0_waitRequest ? FILL_REQ : FILL_DATA;
        end
        FILL_DATA: begin
          s0_readDataValid = m0_readDataValid && beat == wo;
          s0_readData = m0_readDataValid && beat == wo ? m0_readData : '0;
          state_n = last_beat ? IDLE : FILL_DATA;
        end
        WR_BUS, IO_REQ: begin
          m0_read = !wr;
          m0_write = wr;
          m0_address = {addr[31:2], 2'b00};
          m0_byteEnable = wr ? be : 4'hF;
          m0_writeData = wr ? wdata : '0;
          m0_burstCount = BURST_W'(1);
          m0_beginBurstTransfer = first;
          state_n = m0_waitRequest ? state : wr ? IDLE : IO_DATA;
        end
        IO_DATA: begin
          s0_readDataValid = m0_readDataValid;
          s0_readData = m0_readDataValid ? m0_readData : '0;
          state_n = m0_readDataValid ? IDLE : IO_DATA;
        end
        FLUSH: begin
          flush_done = &fl_cnt;
          state_n = &fl_cnt ? IDLE : FLUSH;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    state <= rest ? IDLE : state_n;
    first <= !rest && state_n != state;
  end
  always_ff @(posedge clk)
    if (rest) begin
      flush_pend <= 1'b0;
      fl_cnt <= '0;
      beat <= '0;
      victim <= '0;
      victim_valid <= 1'b0;
      for (int i = 0; i < WAYS; i++) valid[i] <= '0;
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      flush_pend <= state == IDLE && flush_pend ? 1'b0 : flush_pend || (flush_req && state != FLUSH);
      if (state == LOOKUP) begin
        victim <= vic;
        victim_valid <= !vic_inv;
      end
      if (state == FILL_REQ) beat <= '0;
      else if (fill_beat) beat <= beat + 1'b1;
      // Only a completed fill marks the line valid.
      if (last_beat) begin
        valid[victim][idx] <= 1'b1;
        if (victim_valid) ptr[idx] <= ptr[idx] == WW'(WAYS - 1) ? '0 : ptr[idx] + 1'b1;
      end
      if (state == FLUSH) begin
        for (int i = 0; i < WAYS; i++) valid[i][fl_cnt] <= 1'b0;
        fl_cnt <= fl_cnt + 1'b1;
      end
    end
  always_ff @(posedge clk) begin
    if (accept) begin
      addr <= s0_address;
      wdata <= s0_writeData;
      be <= s0_byteEnable;
      wr <= s0_write;
      for (int i = 0; i < WAYS; i++) begin
        rd_tag[i] <= tag_mem[i][a_idx];
        rd_data[i] <= data_mem[i][{a_idx, a_wo}];
      end
    end
    if (!rest && state == LOOKUP && wr && hit) data_mem[hit_way][{idx, wo}] <= merged;
    if (fill_beat) data_mem[victim][{idx, beat}] <= m0_readData;
    if (last_beat) tag_mem[victim][idx] <= tag;
  end
`ifdef CACHE_WT_STATS_EN
  always_ff @(posedge clk)
    if (rest || flush_done) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP && !wr) begin
      if (hit && !(&stat_hits)) stat_hits <= stat_hits + 32'd1;
      if (!hit && !(&stat_misses)) stat_misses <= stat_misses + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cache_wt_nway.sv
// tb_cache_wt_nway: directed scoreboard bench for cache_wt_nway (default parameters).
module tb_cache_wt_nway;
  logic clk = 1'b0, rest = 1'b1;
  logic [31:0] s0_address = '0, s0_writeData = '0, s0_readData;
  logic [3:0] s0_byteEnable = '0;
  logic s0_read = 1'b0, s0_write = 1'b0, s0_waitRequest, s0_readDataValid;
  logic [31:0] m0_address, m0_writeData, m0_readData = '0;
  logic [3:0] m0_byteEnable;
  logic m0_read, m0_write, m0_waitRequest = 1'b0, m0_readDataValid = 1'b0, m0_beginBurstTransfer;
  logic [7:0] m0_burstCount;
  logic flush_req = 1'b0, flush_done;
`ifdef CACHE_WT_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif
  typedef struct packed {logic w; logic [31:0] a; logic [7:0] n; logic [3:0] be; logic [31:0] d;} txn_t;
  txn_t exp_bus[$];
  txn_t cur;
  logic [31:0] exp_rd[$];
  logic [31:0] rq[$];
  logic [31:0] bus_mem [logic [31:0]];
  int total = 0, bad = 0, bus_cnt = 0, fd_cnt = 0, beg_cnt = 0;
  bit stalled = 0;

  cache_wt_nway dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writeData(s0_writeData), .s0_waitRequest(s0_waitRequest), .s0_readData(s0_readData),
    .s0_readDataValid(s0_readDataValid),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writeData(m0_writeData), .m0_waitRequest(m0_waitRequest), .m0_readData(m0_readData),
    .m0_readDataValid(m0_readDataValid), .m0_beginBurstTransfer(m0_beginBurstTransfer),
    .m0_burstCount(m0_burstCount), .flush_req(flush_req),
`ifdef CACHE_WT_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : a ^ 32'h5A5A_0000;
  endfunction

  task automatic exp_txn(logic w, logic [31:0] a, logic [7:0] n, logic [3:0] b, logic [31:0] d);
    txn_t t;
    t.w = w; t.a = a; t.n = n; t.be = b; t.d = d;
    exp_bus.push_back(t);
  endtask

  // Bus slave: one wait state per request, read beats returned from the cycle after acceptance.
  always @(posedge clk) begin
    #1;
    m0_readDataValid = 1'b0;
    m0_readData = '0;
    if (rest) begin
      rq.delete();
      stalled = 0;
      m0_waitRequest = 1'b0;
    end else begin
      if (rq.size() > 0) begin
        m0_readDataValid = 1'b1;
        m0_readData = rq.pop_front();
      end
      if (m0_read || m0_write) begin
        if (m0_beginBurstTransfer) beg_cnt++;
        if (!stalled) begin
          m0_waitRequest = 1'b1;
          stalled = 1;
        end else begin
          m0_waitRequest = 1'b0;
          stalled = 0;
          bus_cnt++;
          check("begin_burst_cycles", beg_cnt, 1);
          beg_cnt = 0;
          cur.w = m0_write; cur.a = m0_address; cur.n = m0_burstCount; cur.be = m0_byteEnable;
          cur.d = m0_write ? m0_writeData : 32'h0;
          if (exp_bus.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_unexpected: got %h expected none", cur);
          end else check("bus_txn", cur, exp_bus.pop_front());
          if (m0_write) begin
            logic [31:0] v;
            v = mem_rd(m0_address);
            for (int b = 0; b < 4; b++) if (m0_byteEnable[b]) v[8*b +: 8] = m0_writeData[8*b +: 8];
            bus_mem[m0_address] = v;
          end else for (int i = 0; i < int'(m0_burstCount); i++) rq.push_back(mem_rd(m0_address + 32'(4 * i)));
        end
      end else begin
        m0_waitRequest = 1'b0;
        stalled = 0;
      end
    end
  end

  always @(negedge clk)
    if (s0_readDataValid) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL s0_unexpected: got %h expected none", s0_readData);
      end else check("s0_rdata", s0_readData, exp_rd.pop_front());
    end

  always @(negedge clk) if (flush_done) fd_cnt++;

  task automatic cpu_op(string name, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d, int exp_lat, int exp_delta);
    int lat = -1, nv = 0, n0, k;
    n0 = bus_cnt;
    @(negedge clk);
    s0_address = a; s0_byteEnable = b; s0_writeData = d; s0_read = !w; s0_write = w;
    k = 0;
    while (s0_waitRequest && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (s0_waitRequest) begin
      check({name, "_accept_timeout"}, 1, 0);
      s0_read = 1'b0; s0_write = 1'b0;
      return;
    end
    @(negedge clk);
    s0_read = 1'b0; s0_write = 1'b0;
    for (k = 1; k < 400; k++) begin
      if (s0_readDataValid) begin
        nv++;
        if (lat < 0) lat = k;
      end
      if (!s0_waitRequest) break;
      @(negedge clk);
    end
    check({name, "_idle"}, s0_waitRequest, 0);
    check({name, "_rdv_pulses"}, nv, w ? 0 : 1);
    if (exp_lat > 0) check({name, "_latency"}, lat, exp_lat);
    check({name, "_bus_txns"}, bus_cnt - n0, exp_delta);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_waitreq", s0_waitRequest, 1);
    check("rst_outputs", {m0_read, m0_write, s0_readDataValid, flush_done, m0_beginBurstTransfer}, 0);
    rest = 1'b0;
    @(negedge clk);
    check("idle_waitreq", s0_waitRequest, 0);
    exp_txn(0, 32'h100, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_0104);
    cpu_op("cold_rd", 0, 32'h104, 4'hF, 0, 0, 1);
    exp_rd.push_back(32'h5A5A_0104);
    cpu_op("hit_rd", 0, 32'h104, 4'hF, 0, 1, 0);
    exp_txn(1, 32'h104, 8'd1, 4'h3, 32'hAABB_CCDD);
    cpu_op("wr_hit", 1, 32'h104, 4'h3, 32'hAABB_CCDD, 0, 1);
    exp_rd.push_back(32'h5A5A_CCDD);
    cpu_op("rd_after_wr", 0, 32'h104, 4'hF, 0, 1, 0);
    exp_txn(0, 32'h000, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_0000);
    cpu_op("rd_000", 0, 32'h000, 4'hF, 0, 0, 1);
    exp_txn(0, 32'h400, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_0400);
    cpu_op("rd_400", 0, 32'h400, 4'hF, 0, 0, 1);
    exp_txn(0, 32'h800, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_0800);
    cpu_op("rd_800_evict", 0, 32'h800, 4'hF, 0, 0, 1);
    exp_rd.push_back(32'h5A5A_0400);
    cpu_op("rd_400_hit", 0, 32'h400, 4'hF, 0, 1, 0);
    exp_txn(0, 32'h000, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_0000);
    cpu_op("rd_000_remiss", 0, 32'h000, 4'hF, 0, 0, 1);
    exp_rd.push_back(32'h5A5A_0800);
    cpu_op("rd_800_hit", 0, 32'h800, 4'hF, 0, 1, 0);
    exp_txn(1, 32'h2000, 8'd1, 4'hF, 32'h1234_5678);
    cpu_op("wr_miss", 1, 32'h2000, 4'hF, 32'h1234_5678, 0, 1);
    exp_txn(0, 32'h2000, 8'd4, 4'hF, 0); exp_rd.push_back(32'h1234_5678);
    cpu_op("rd_no_alloc", 0, 32'h2000, 4'hF, 0, 0, 1);
    exp_txn(0, 32'hF000_0010, 8'd1, 4'hF, 0); exp_rd.push_back(32'hAA5A_0010);
    cpu_op("io_rd", 0, 32'hF000_0010, 4'hF, 0, 0, 1);
    exp_txn(0, 32'hF000_0010, 8'd1, 4'hF, 0); exp_rd.push_back(32'hAA5A_0010);
    cpu_op("io_rerd", 0, 32'hF000_0010, 4'hF, 0, 0, 1);
    exp_txn(1, 32'hF000_0020, 8'd1, 4'hC, 32'h1122_3344);
    cpu_op("io_wr", 1, 32'hF000_0020, 4'hC, 32'h1122_3344, 0, 1);
    exp_txn(0, 32'h300, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_0300);
    fork
      cpu_op("flush_fill", 0, 32'h300, 4'hF, 0, 0, 1);
      begin
        repeat (3) @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (20) @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
      end
    join
    check("flush_done_pulses", fd_cnt, 1);
    exp_txn(0, 32'h100, 8'd4, 4'hF, 0); exp_rd.push_back(32'h5A5A_CCDD);
    cpu_op("rd_after_flush", 0, 32'h104, 4'hF, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("bus_queue_drained", exp_bus.size(), 0);
    check("s0_queue_drained", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
